// File: rtl/rca_seq_ctrl.sv
// Sequential adder: {cout,sum} = a + b + cin, computed by a single 4-bit
// ripple-carry slice that is reused once per nibble, least significant first.

module four_bit_RCA (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [4:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[4];

endmodule

module rca_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic [3:0]       sliceA;
    logic [3:0]       sliceB;
    logic [3:0]       sliceSum;
    logic             sliceCout;

    assign sliceA = opA_q[{cnt_q, 2'b00} +: 4];
    assign sliceB = opB_q[{cnt_q, 2'b00} +: 4];

    four_bit_RCA u_slice (
        .a_i   (sliceA),
        .b_i   (sliceB),
        .cin_i (carry_q),
        .sum_o (sliceSum),
        .cout_o(sliceCout)
    );

    // Result with the current step's nibble merged in, so the final step can
    // publish the complete word in the same edge that computes its top nibble.
    always_comb begin
        res_d = res_q;
        res_d[{cnt_q, 2'b00} +: 4] = sliceSum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        opA_q   <= a;
                        opB_q   <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= sliceCout;
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= sliceCout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench for rca_seq_ctrl: expected results come from plain 33-bit
// addition and a cycle-index timing model; a negedge monitor checks outputs.

module tb_rca_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             cin   = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        int               acceptEdge;
    } expItem_t;

    expItem_t         sbQ[$];
    int               cyc        = 0;
    logic             rstEdge    = 1'b0;
    bit               armed      = 1'b0;
    int               checkCount = 0;
    int               passCount  = 0;
    logic [WIDTH-1:0] expSum     = '0;
    logic             expCout    = 1'b0;
    logic             prevDone   = 1'b0;
    int               idx;
    logic             busyExp;
    logic             doneExp;
    expItem_t         popped;

    // Edge counter and a record of whether reset was applied on this edge.
    always @(posedge clk) begin
        cyc     = cyc + 1;
        rstEdge = rst;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp)
            passCount++;
        else
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one start; the expected result is the plain arithmetic sum.
    task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB, input logic c);
        expItem_t   e;
        logic [WIDTH:0] full;
        full         = {1'b0, opA} + {1'b0, opB} + {{WIDTH{1'b0}}, c};
        e.sum        = full[WIDTH-1:0];
        e.cout       = full[WIDTH];
        e.acceptEdge = cyc + 1;
        sbQ.push_back(e);
        a     = opA;
        b     = opB;
        cin   = c;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic applyReset(input logic withStart);
        rst   = 1'b1;
        start = withStart;
        a     = $urandom;
        b     = $urandom;
        step();
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset sum",  64'(sum),  64'd0);
        checkOutput("reset cout", 64'(cout), 64'd0);
        step();
    endtask

    task automatic waitIdle();
        int n = 0;
        while (sbQ.size() != 0 && n < 40) begin
            step();
            n++;
        end
        checkOutput("drain", 64'(sbQ.size()), 64'd0);
        sbQ.delete();
    endtask

    // Monitor: cycle index k after the accepting edge gives busy for k=1..NIB
    // and done at k=NIB+1; sum/cout change only when a result is delivered.
    always @(negedge clk) begin
        if (armed) begin
            if (rstEdge) begin
                sbQ.delete();
                expSum  = '0;
                expCout = 1'b0;
            end
            busyExp = 1'b0;
            doneExp = 1'b0;
            if (sbQ.size() > 0) begin
                idx     = cyc - sbQ[0].acceptEdge + 1;
                busyExp = (idx >= 1) && (idx <= NIB);
                doneExp = (idx == NIB + 1);
            end
            checkOutput("busy", 64'(busy), 64'(busyExp));
            checkOutput("done", 64'(done), 64'(doneExp));
            if ((done || doneExp) && sbQ.size() > 0) begin
                popped  = sbQ.pop_front();
                expSum  = popped.sum;
                expCout = popped.cout;
                checkOutput("done single-cycle", 64'(prevDone), 64'd0);
            end
            checkOutput("sum",  64'(sum),  64'(expSum));
            checkOutput("cout", 64'(cout), 64'(expCout));
            prevDone = done;
        end
    end

    initial begin
        logic            b2b;
        logic [WIDTH-1:0] r1;
        logic [WIDTH-1:0] r2;

        armed = 1'b1;
        $display("[TB] reset with start also high");
        applyReset(1'b1);
        step();

        $display("[TB] reference vector");
        applyStimulus(32'hDABC9875, 32'hEFBC9615, 1'b0);
        waitIdle();
        checkOutput("vec1 sum",  64'(sum),  64'h0000_0000_CA79_2E8A);
        checkOutput("vec1 cout", 64'(cout), 64'd1);

        $display("[TB] full carry propagation");
        applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b1);
        waitIdle();
        checkOutput("vec2 sum",  64'(sum),  64'd0);
        checkOutput("vec2 cout", 64'(cout), 64'd1);

        $display("[TB] operand changes while busy");
        applyStimulus(32'h00000000, 32'h00000001, 1'b0);
        a   = 32'hFFFFFFFF;
        b   = 32'h12345678;
        cin = 1'b1;
        waitIdle();
        checkOutput("vec3 sum",  64'(sum),  64'd1);
        checkOutput("vec3 cout", 64'(cout), 64'd0);

        $display("[TB] start pulse during RUN");
        applyStimulus(32'h13572468, 32'h8ACE0246, 1'b1);
        step();
        step();
        a     = 32'hAAAA5555;
        b     = 32'h5555AAAA;
        start = 1'b1;
        step();
        start = 1'b0;
        waitIdle();

        $display("[TB] back-to-back start in DONE");
        applyStimulus(32'h0F0F0F0F, 32'hF0F0F0F1, 1'b0);
        repeat (NIB) step();
        applyStimulus(32'h00000010, 32'h00000020, 1'b0);
        waitIdle();
        checkOutput("vec5 sum", 64'(sum), 64'h30);

        $display("[TB] reset during RUN");
        applyStimulus(32'h89ABCDEF, 32'h76543210, 1'b1);
        repeat (3) step();
        applyReset(1'b0);
        repeat (12) step();

        $display("[TB] randomized transactions");
        for (int i = 0; i < 24; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            if ($urandom_range(0, 4) == 0) r1 = '1;
            applyStimulus(r1, r2, 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                a   = $urandom;
                b   = $urandom;
                cin = 1'($urandom);
            end
            for (int k = 1; k < NIB; k++) begin
                start = ($urandom_range(0, 5) == 0);
                step();
            end
            start = 1'b0;
            step();
            b2b = ($urandom_range(0, 1) == 1) && (i < 23);
            if (!b2b) begin
                step();
                repeat ($urandom_range(0, 3)) step();
            end
        end
        waitIdle();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
